// File: rtl/dpram_bist_master_if.sv
// Port bundle between the BIST initiator and the 32x8 dual-port RAM.
// The master modport drives both RAM ports and receives read data.
interface dpram_bist_master_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) ();
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              wr;
    logic [ADDR_W-1:0] r_addr;
    logic              rd;
    logic              enb;
    logic [DATA_W-1:0] r_data;

    modport master (
        output w_addr, w_data, wr, r_addr, rd, enb,
        input  r_data
    );

    modport slave (
        input  w_addr, w_data, wr, r_addr, rd, enb,
        output r_data
    );
endinterface

// File: rtl/dpram_bist_master.sv
// Dual-port RAM self-test initiator: true-data then inverted-data write/read-compare
// passes over the full depth, reporting pass/fail, mismatch count and first failure.
module dpram_bist_master #(
    parameter int unsigned       ADDR_W = 5,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    dpram_bist_master_if.master ram,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                first_err_phase
);
    localparam int unsigned CNT_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic                rd_q, rd_d;
    logic                enb_q, enb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
    logic                first_phase_q, first_phase_d;

    logic                pend_valid_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic                pend_phase_q;

    logic                accept;
    logic                last;
    logic                phase_d;
    logic                cmp_err;

    // Pattern for address a; inv selects the complemented pass
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] v;
        v = SEED + DATA_W'(a);
        return inv ? ~v : v;
    endfunction

    // Next state, sequencing address and next values of every registered output
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        accept        = 1'b0;
        last          = &addr_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WR0;
                    addr_d  = '0;
                    accept  = 1'b1;
                end
            end
            WR0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last) state_d = RD0;
            end
            RD0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last) state_d = WR1;
            end
            WR1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last) state_d = RD1;
            end
            RD1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last) state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        wr_d     = (state_d == WR0) || (state_d == WR1);
        rd_d     = (state_d == RD0) || (state_d == RD1);
        phase_d  = (state_d == WR1) || (state_d == RD1);
        enb_d    = wr_d | rd_d;
        w_addr_d = wr_d ? addr_d : '0;
        w_data_d = wr_d ? exp_data(addr_d, phase_d) : '0;
        r_addr_d = rd_d ? addr_d : '0;
        busy_d   = wr_d | rd_d | (state_d == DRAIN);

        // Read data for the read issued one edge earlier is checked here
        cmp_err       = pend_valid_q && (ram.r_data != exp_data(pend_addr_q, pend_phase_q));
        err_cnt_d     = err_cnt_q;
        first_addr_d  = first_addr_q;
        first_phase_d = first_phase_q;
        if (accept) begin
            err_cnt_d     = '0;
            first_addr_d  = '0;
            first_phase_d = 1'b0;
        end else if (cmp_err) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) begin
                first_addr_d  = pend_addr_q;
                first_phase_d = pend_phase_q;
            end
        end

        done_d = (state_d == DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            wr_q          <= 1'b0;
            r_addr_q      <= '0;
            rd_q          <= 1'b0;
            enb_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_cnt_q     <= '0;
            first_addr_q  <= '0;
            first_phase_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_phase_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            w_addr_q      <= w_addr_d;
            w_data_q      <= w_data_d;
            wr_q          <= wr_d;
            r_addr_q      <= r_addr_d;
            rd_q          <= rd_d;
            enb_q         <= enb_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_cnt_q     <= err_cnt_d;
            first_addr_q  <= first_addr_d;
            first_phase_q <= first_phase_d;
            // A read presented this cycle is sampled by the RAM at this edge
            pend_valid_q  <= rd_q;
            pend_addr_q   <= r_addr_q;
            pend_phase_q  <= (state_q == RD1);
        end
    end

    assign ram.w_addr      = w_addr_q;
    assign ram.w_data      = w_data_q;
    assign ram.wr          = wr_q;
    assign ram.r_addr      = r_addr_q;
    assign ram.rd          = rd_q;
    assign ram.enb         = enb_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = first_addr_q;
    assign first_err_phase = first_phase_q;
endmodule

// File: tb/tb_dpram_bist_master.sv
// Bench for dpram_bist_master: RAM model with injectable faults, cycle-exact
// strobe/address/data checks and a pass-level mismatch reference model.
module tb_dpram_bist_master;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int          DEPTH  = 32;
    localparam logic [7:0]  SEED   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic [6:0] err_cnt;
    logic [4:0] first_err_addr;
    logic       first_err_phase;

    int n_chk  = 0;
    int n_fail = 0;

    dpram_bist_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

    dpram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .ram             (ram_if),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_addr  (first_err_addr),
        .first_err_phase (first_err_phase)
    );

    always #5 clk = ~clk;

    // RAM model: read data = (stored ^ xor_tab[phase][addr]) & and_mask
    logic [7:0] mem     [DEPTH];
    logic [7:0] xor_tab [2*DEPTH];
    logic [7:0] and_mask;
    logic [5:0] rd_seen;

    always @(posedge clk) begin
        if (ram_if.wr) mem[ram_if.w_addr] <= ram_if.w_data;
        if (rst) begin
            rd_seen       <= '0;
            ram_if.r_data <= '0;
        end else if (ram_if.rd) begin
            ram_if.r_data <= (mem[ram_if.r_addr] ^ xor_tab[{rd_seen[5], ram_if.r_addr}]) & and_mask;
            rd_seen       <= rd_seen + 6'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a, input int ph);
        logic [7:0] v;
        v = SEED + 8'(a);
        return (ph != 0) ? ~v : v;
    endfunction

    // Expected run results straight from the RAM fault description
    function automatic void model(output int cnt, output int fa, output int fp);
        logic [7:0] e, got;
        cnt = 0; fa = 0; fp = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e   = pat(a, ph);
                got = (e ^ xor_tab[ph*DEPTH + a]) & and_mask;
                if (got != e) begin
                    if (cnt == 0) begin fa = a; fp = ph; end
                    cnt++;
                end
            end
        end
    endfunction

    // Invariants on every cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_rd_exclusive", 64'(ram_if.wr & ram_if.rd), 64'(0));
            chk("enb_eq_wr_or_rd", 64'(ram_if.enb), 64'(ram_if.wr | ram_if.rd));
        end
    end

    // Runs one test from the start edge, checking each cycle after E0..E(kmax)
    task automatic run_check(input string tag, input bit hold, input bit already,
                             input int e_cnt, input int e_fa, input int e_fp);
        int   kmax;
        logic ewr, erd;
        int   a, ph;
        kmax = hold ? 129 : 132;
        if (!already) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k <= kmax; k++) begin
            if (hold) start = 1'b1;
            else      start = (k < 128) ? 1'($urandom_range(0, 1)) : 1'b0;
            ewr = (k < 32) || (k >= 64 && k < 96);
            erd = (k >= 32 && k < 64) || (k >= 96 && k < 128);
            a   = k % DEPTH;
            ph  = (k >= 64) ? 1 : 0;
            chk($sformatf("%s strobes{wr,rd,enb,busy,done} k=%0d", tag, k),
                64'({ram_if.wr, ram_if.rd, ram_if.enb, busy, done}),
                64'({ewr, erd, ewr | erd, k <= 128, k >= 129}));
            if (ewr) begin
                chk($sformatf("%s w_addr k=%0d", tag, k), 64'(ram_if.w_addr), 64'(a));
                chk($sformatf("%s w_data k=%0d", tag, k), 64'(ram_if.w_data), 64'(pat(a, ph)));
            end
            if (erd) chk($sformatf("%s r_addr k=%0d", tag, k), 64'(ram_if.r_addr), 64'(a));
            if (k >= 129) begin
                chk($sformatf("%s err_cnt k=%0d", tag, k), 64'(err_cnt), 64'(e_cnt));
                chk($sformatf("%s first_err_addr k=%0d", tag, k), 64'(first_err_addr), 64'(e_fa));
                chk($sformatf("%s first_err_phase k=%0d", tag, k), 64'(first_err_phase), 64'(e_fp));
                chk($sformatf("%s pass k=%0d", tag, k), 64'(pass), 64'(e_cnt == 0));
            end
            if (k < kmax) @(negedge clk);
        end
    endtask

    task automatic clear_faults();
        and_mask = 8'hFF;
        for (int i = 0; i < 2*DEPTH; i++) xor_tab[i] = 8'h00;
    endtask

    typedef struct {
        logic [7:0] mask;
        int         xph;
        int         xaddr;
        logic [7:0] xval;
        int         e_cnt;
        int         e_fa;
        int         e_fp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int m_cnt, m_fa, m_fp;

        vecs[0] = '{8'hFF, 0,  0, 8'h00,  0,  0, 0};  // ideal RAM
        vecs[1] = '{8'hFE, 0,  0, 8'h00, 32,  0, 0};  // r_data bit0 stuck-at-0
        vecs[2] = '{8'hFF, 1,  5, 8'h10,  1,  5, 1};  // addr 5 bad in inverted pass
        vecs[3] = '{8'hFF, 0, 31, 8'h01,  1, 31, 0};  // last RD0 compare, overlaps WR1
        vecs[4] = '{8'hFF, 1, 31, 8'h80,  1, 31, 1};  // last RD1 compare, in DRAIN

        rst   = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset outputs",
            64'({ram_if.w_addr, ram_if.r_addr, ram_if.w_data, ram_if.wr, ram_if.rd, ram_if.enb,
                 busy, done, pass, err_cnt, first_err_addr, first_err_phase}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            clear_faults();
            and_mask = vecs[i].mask;
            xor_tab[vecs[i].xph*DEPTH + vecs[i].xaddr] = vecs[i].xval;
            run_check($sformatf("vec%0d", i), 1'b0, 1'b0, vecs[i].e_cnt, vecs[i].e_fa, vecs[i].e_fp);
        end

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            for (int i = 0; i < 2*DEPTH; i++)
                xor_tab[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if ($urandom_range(0, 3) == 0) and_mask = ~(8'h01 << $urandom_range(0, 7));
            model(m_cnt, m_fa, m_fp);
            run_check($sformatf("rand%0d", r), 1'b0, 1'b0, m_cnt, m_fa, m_fp);
        end

        // start held high: DONE lasts one cycle, next run begins immediately
        clear_faults();
        run_check("hold_a", 1'b1, 1'b0, 0, 0, 0);
        @(negedge clk);
        run_check("hold_b", 1'b0, 1'b1, 0, 0, 0);

        // rst at E50 of a faulty run, then a clean run
        and_mask = 8'hFE;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("busy before mid-run rst", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("outputs after mid-run rst",
            64'({ram_if.w_addr, ram_if.r_addr, ram_if.w_data, ram_if.wr, ram_if.rd, ram_if.enb,
                 busy, done, pass, err_cnt, first_err_addr, first_err_phase}), 64'(0));
        rst = 1'b0;
        clear_faults();
        @(negedge clk);
        @(negedge clk);
        chk("idle after rst", 64'({busy, done, ram_if.enb}), 64'(0));
        run_check("post_rst", 1'b0, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "simulation time limit");
    end
endmodule
